scarv_cop_palu_ctrl: RTL and testbench
======================================

# scarv_cop_palu_ctrl

Issue and writeback sequencer for the coprocessor packed ALU. It accepts one decoded PALU instruction at a time and registers its operands. It holds `palu_ivalid` until the PALU reports completion, which covers both single-cycle ops and the multi-cycle packed multiply. It then arbitrates the single CPR write port between the buffered PALU result and the memory-unit writeback requester.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum EXEC cycles before the in-flight instruction is aborted.

Ports:
- `g_clk` in 1: clock; all state on rising edge.
- `g_reset` in 1: reset, asynchronous, active-high.
- `id_valid` in 1 / `id_ready` out 1: instruction handshake; transfer when both are high.
- `id_rs1`, `id_rs2`, `id_rs3`, `id_gpr_rs1`, `id_imm` in 32 each: operands.
- `id_pw` in 3, `id_class` in 3, `id_subclass` in 4: op fields.
- `id_rd` in 4: destination CPR.
- `palu_ivalid` out 1: instruction valid to PALU.
- `palu_idone` in 1: PALU completion.
- `palu_rs1`, `palu_rs2`, `palu_rs3`, `palu_gpr_rs1`, `palu_imm` out 32; `palu_pw` out 3; `palu_class` out 3; `palu_subclass` out 4: registered operands to PALU.
- `palu_cpr_rd_ben` in 4, `palu_cpr_rd_wdata` in 32: PALU result.
- `mem_wen` in 1, `mem_rd` in 4, `mem_wdata` in 32: memory writeback request, held until acked.
- `mem_ack` out 1: memory request granted this cycle.
- `cpr_rd_addr` out 4, `cpr_rd_ben` out 4, `cpr_rd_wdata` out 32: CPR write port.
- `ctrl_busy` out 1: state is not IDLE.
- `ctrl_err` out 1: one-cycle timeout pulse.

## Operation
States and transitions:
- **IDLE**
  - `id_ready`=1.
  - On handshake: capture all `id_*` into operand registers, clear cycle counter, go to EXEC.
- **EXEC**
  - `palu_ivalid`=1, driven from the operand registers; counter increments each cycle.
  - `palu_idone`=1: capture `palu_cpr_rd_ben`/`palu_cpr_rd_wdata` into the result buffer, go to WB.
  - Counter = `TIMEOUT`-1 with `palu_idone`=0: go to IDLE, result discarded, `ctrl_err`=1 next cycle.
- **WB**
  - Buffered ben = 0 (CMOV not taken): no port request; go to IDLE next cycle.
  - Otherwise request the port; on grant write {`rd`, ben, data} and go to IDLE; if not granted, stay in WB.

CPR port arbitration (combinational, 2 requesters):
- One round-robin pointer `rr`: 0 favours PALU, 1 favours memory.
- Only one requester: it wins.
- Both request: `rr` decides.
- On every grant, `rr` points at the requester that did not win.
- `mem_ack` = memory granted. `cpr_rd_*` carry the winner's fields.
- No grant: `cpr_rd_ben`=0, `cpr_rd_addr`=0, `cpr_rd_wdata`=0.
- Memory can win while the controller is in IDLE or EXEC; only the WB state competes.

Operand and result registers change only on capture. Widths pass through unchanged; no arithmetic beyond the counter, which is `$clog2(TIMEOUT)` bits and does not wrap in a legal run.

## Timing
- Reset values:
  - state IDLE, so `id_ready`=1 and `ctrl_busy`=0;
  - `palu_ivalid`=0, `ctrl_err`=0, `rr`=0;
  - all operand and result registers 0;
  - `cpr_rd_ben`=0, `mem_ack`=0.
- Latency for a single-cycle op, uncontended:
  - handshake at cycle 0;
  - `palu_ivalid` in cycle 1, with `palu_idone` in the same cycle;
  - CPR write in cycle 2;
  - `id_ready` back in cycle 3.
- Throughput: one instruction per 3 cycles minimum.
- Multi-cycle op taking N cycles of `palu_ivalid`: write in cycle N+1.
- Contention: a PALU loss in WB adds one cycle per lost arbitration; `rr` guarantees a win within 2 cycles.
- Reset mid-operation: the FSM returns to IDLE asynchronously, any buffered result is dropped, and nothing is written.
- `palu_ivalid` deasserts the cycle after `palu_idone` or after a timeout.
- `id_valid` in a non-IDLE state is ignored (`id_ready`=0).

## Configuration
- **`SCARV_COP_PALU_CTRL_TIMEOUT_EN` defined:** counter, timeout abort and `ctrl_err` are implemented as above.
- **Undefined:**
  - EXEC waits indefinitely for `palu_idone`;
  - no counter is instantiated;
  - `ctrl_err` is tied 0;
  - `TIMEOUT` is ignored.

## Test plan
- **ADD.PX, uncontended:** `id_rs1`=0x00010002, `id_rs2`=0x00030004, `id_rd`=5, PALU returns `palu_idone` in cycle 1 with ben=0xF, data=0x00040006 → cycle 2: `cpr_rd_addr`=5, `cpr_rd_ben`=0xF, `cpr_rd_wdata`=0x00040006; `id_ready`=1 in cycle 3.
- **Multiply, 4 cycles:** `palu_idone` in the 4th EXEC cycle → `palu_ivalid` high exactly 4 cycles; write in cycle 5; `ctrl_busy` high cycles 1-5.
- **CMOV not taken:** PALU returns ben=0 → no `cpr_rd_ben` pulse; back in IDLE in cycle 3.
- **Contention:** PALU in WB and `mem_wen`=1 (`mem_rd`=3, data 0xDEADBEEF) with `rr`=0 → PALU writes first; next cycle `mem_ack`=1 and CPR 3 is written with 0xDEADBEEF; `rr` ends at 0.
- **Timeout:** `TIMEOUT`=8, `palu_idone` never asserted → `palu_ivalid` high 8 cycles, `ctrl_err` a single pulse, no CPR write. With the macro undefined → `palu_ivalid` stays high and `ctrl_err` stays 0.
- **Reset mid-op:** `g_reset` asserted in EXEC cycle 2 → `palu_ivalid`=0 and `id_ready`=1 immediately, with no CPR write after release.

Source files
------------

// File: rtl/scarv_cop_palu_ctrl_if.sv
// Bundle of the PALU sequencer's decode, PALU, memory-writeback and CPR ports.
// master is the sequencer side, slave is the surrounding core/testbench side.
interface scarv_cop_palu_ctrl_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_rs1;
    logic [31:0] id_rs2;
    logic [31:0] id_rs3;
    logic [31:0] id_gpr_rs1;
    logic [31:0] id_imm;
    logic [2:0]  id_pw;
    logic [2:0]  id_class;
    logic [3:0]  id_subclass;
    logic [3:0]  id_rd;

    logic        palu_ivalid;
    logic        palu_idone;
    logic [31:0] palu_rs1;
    logic [31:0] palu_rs2;
    logic [31:0] palu_rs3;
    logic [31:0] palu_gpr_rs1;
    logic [31:0] palu_imm;
    logic [2:0]  palu_pw;
    logic [2:0]  palu_class;
    logic [3:0]  palu_subclass;
    logic [3:0]  palu_cpr_rd_ben;
    logic [31:0] palu_cpr_rd_wdata;

    logic        mem_wen;
    logic [3:0]  mem_rd;
    logic [31:0] mem_wdata;
    logic        mem_ack;

    logic [3:0]  cpr_rd_addr;
    logic [3:0]  cpr_rd_ben;
    logic [31:0] cpr_rd_wdata;
    logic        ctrl_busy;
    logic        ctrl_err;

    modport master (
        input  id_valid, id_rs1, id_rs2, id_rs3, id_gpr_rs1, id_imm,
        input  id_pw, id_class, id_subclass, id_rd,
        output id_ready,
        output palu_ivalid, palu_rs1, palu_rs2, palu_rs3, palu_gpr_rs1,
        output palu_imm, palu_pw, palu_class, palu_subclass,
        input  palu_idone, palu_cpr_rd_ben, palu_cpr_rd_wdata,
        input  mem_wen, mem_rd, mem_wdata,
        output mem_ack,
        output cpr_rd_addr, cpr_rd_ben, cpr_rd_wdata, ctrl_busy, ctrl_err
    );

    modport slave (
        output id_valid, id_rs1, id_rs2, id_rs3, id_gpr_rs1, id_imm,
        output id_pw, id_class, id_subclass, id_rd,
        input  id_ready,
        input  palu_ivalid, palu_rs1, palu_rs2, palu_rs3, palu_gpr_rs1,
        input  palu_imm, palu_pw, palu_class, palu_subclass,
        output palu_idone, palu_cpr_rd_ben, palu_cpr_rd_wdata,
        output mem_wen, mem_rd, mem_wdata,
        input  mem_ack,
        input  cpr_rd_addr, cpr_rd_ben, cpr_rd_wdata, ctrl_busy, ctrl_err
    );
endinterface

// File: rtl/scarv_cop_palu_ctrl.sv
// PALU issue/writeback sequencer with a round-robin CPR write-port arbiter.
// Define SCARV_COP_PALU_CTRL_TIMEOUT_EN to add the EXEC watchdog and ctrl_err.
module scarv_cop_palu_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    scarv_cop_palu_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_ready;
    logic        r_ivalid;
    logic        r_busy;
    logic        r_err;
    logic        r_rr;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_rs3;
    logic [31:0] r_gpr_rs1;
    logic [31:0] r_imm;
    logic [2:0]  r_pw;
    logic [2:0]  r_class;
    logic [3:0]  r_subclass;
    logic [3:0]  r_rd;
    logic [3:0]  r_res_ben;
    logic [31:0] r_res_data;

    logic w_take;
    logic w_done;
    logic w_abort;
    logic w_preq;
    logic w_pgnt;
    logic w_mgnt;

    assign w_take = (r_state == S_IDLE) && bus.id_valid;
    assign w_done = (r_state == S_EXEC) && bus.palu_idone;

`ifdef SCARV_COP_PALU_CTRL_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    assign w_abort = (r_state == S_EXEC) && !bus.palu_idone
                   && (r_cnt == LAST);

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_cnt <= '0;
        end else if (w_take) begin
            r_cnt <= '0;
        end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (bus.id_valid) w_next = S_EXEC;
            S_EXEC: begin
                if (bus.palu_idone) w_next = S_WB;
                else if (w_abort)   w_next = S_IDLE;
            end
            S_WB: if (r_res_ben == 4'd0 || w_pgnt) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // PALU wins unless memory also asks and the pointer favours memory.
    assign w_preq = (r_state == S_WB) && (r_res_ben != 4'd0);
    assign w_pgnt = w_preq && (!bus.mem_wen || !r_rr);
    assign w_mgnt = bus.mem_wen && !w_pgnt;

    assign bus.mem_ack      = w_mgnt;
    assign bus.cpr_rd_addr  = w_pgnt ? r_rd
                            : (w_mgnt ? bus.mem_rd : 4'd0);
    assign bus.cpr_rd_ben   = w_pgnt ? r_res_ben
                            : (w_mgnt ? 4'hF : 4'd0);
    assign bus.cpr_rd_wdata = w_pgnt ? r_res_data
                            : (w_mgnt ? bus.mem_wdata : 32'd0);

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_ivalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_rr       <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rs3      <= '0;
            r_gpr_rs1  <= '0;
            r_imm      <= '0;
            r_pw       <= '0;
            r_class    <= '0;
            r_subclass <= '0;
            r_rd       <= '0;
            r_res_ben  <= '0;
            r_res_data <= '0;
        end else begin
            r_state  <= w_next;
            r_ready  <= (w_next == S_IDLE);
            r_ivalid <= (w_next == S_EXEC);
            r_busy   <= (w_next != S_IDLE);
            r_err    <= w_abort;
            if (w_pgnt)      r_rr <= 1'b1;
            else if (w_mgnt) r_rr <= 1'b0;
            if (w_take) begin
                r_rs1      <= bus.id_rs1;
                r_rs2      <= bus.id_rs2;
                r_rs3      <= bus.id_rs3;
                r_gpr_rs1  <= bus.id_gpr_rs1;
                r_imm      <= bus.id_imm;
                r_pw       <= bus.id_pw;
                r_class    <= bus.id_class;
                r_subclass <= bus.id_subclass;
                r_rd       <= bus.id_rd;
            end
            if (w_done) begin
                r_res_ben  <= bus.palu_cpr_rd_ben;
                r_res_data <= bus.palu_cpr_rd_wdata;
            end
        end
    end

    assign bus.id_ready      = r_ready;
    assign bus.palu_ivalid   = r_ivalid;
    assign bus.ctrl_busy     = r_busy;
    assign bus.ctrl_err      = r_err;
    assign bus.palu_rs1      = r_rs1;
    assign bus.palu_rs2      = r_rs2;
    assign bus.palu_rs3      = r_rs3;
    assign bus.palu_gpr_rs1  = r_gpr_rs1;
    assign bus.palu_imm      = r_imm;
    assign bus.palu_pw       = r_pw;
    assign bus.palu_class    = r_class;
    assign bus.palu_subclass = r_subclass;
endmodule

// File: tb/tb_scarv_cop_palu_ctrl.sv
// Bench for scarv_cop_palu_ctrl: vector table, contention, timeout, reset.
// Expected CPR writes are queued at issue and popped as the port fires.
module tb_scarv_cop_palu_ctrl;
    logic g_clk = 1'b0;
    logic g_reset = 1'b0;
    always #5 g_clk = ~g_clk;

    scarv_cop_palu_ctrl_if bus();

    scarv_cop_palu_ctrl #(.TIMEOUT(8)) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (bus.master)
    );

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rs3;
        logic [31:0] gpr;
        logic [31:0] imm;
        logic [2:0]  pw;
        logic [2:0]  cls;
        logic [3:0]  sub;
        logic [3:0]  rd;
        int          lat;
        logic [3:0]  ben;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  ben;
        logic [31:0] data;
    } wr_t;

    wr_t  sb[$];
    vec_t tbl[5];
    int   checks = 0;
    int   errors = 0;

    logic       s_ready;
    logic       s_ivalid;
    logic       s_busy;
    logic       s_err;
    logic       s_ack;
    logic [3:0] s_ben;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // One clock cycle: sample at negedge, score any CPR write, step past posedge.
    task automatic cyc();
        wr_t e;
        @(negedge g_clk);
        s_ready  = bus.id_ready;
        s_ivalid = bus.palu_ivalid;
        s_busy   = bus.ctrl_busy;
        s_err    = bus.ctrl_err;
        s_ack    = bus.mem_ack;
        s_ben    = bus.cpr_rd_ben;
        if (s_ben != 4'd0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got addr %h data %h want none",
                         bus.cpr_rd_addr, bus.cpr_rd_wdata);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.cpr_rd_addr), 32'(e.addr));
                chk("wr_ben", 32'(bus.cpr_rd_ben), 32'(e.ben));
                chk("wr_data", bus.cpr_rd_wdata, e.data);
            end
        end
        @(posedge g_clk);
        #1;
        if (s_ack) bus.mem_wen = 1'b0;
    endtask

    task automatic drive_id(input vec_t v);
        bus.id_valid    = 1'b1;
        bus.id_rs1      = v.rs1;
        bus.id_rs2      = v.rs2;
        bus.id_rs3      = v.rs3;
        bus.id_gpr_rs1  = v.gpr;
        bus.id_imm      = v.imm;
        bus.id_pw       = v.pw;
        bus.id_class    = v.cls;
        bus.id_subclass = v.sub;
        bus.id_rd       = v.rd;
    endtask

    task automatic run_op(input vec_t v);
        wr_t e;
        drive_id(v);
        if (v.ben != 4'd0) begin
            e.addr = v.rd;
            e.ben  = v.ben;
            e.data = v.data;
            sb.push_back(e);
        end
        cyc();
        chk("ready_c0", 32'(s_ready), 32'd1);
        bus.id_valid = 1'b0;
        for (int c = 1; c <= v.lat; c++) begin
            bus.palu_idone        = (c == v.lat);
            bus.palu_cpr_rd_ben   = (c == v.lat) ? v.ben : 4'd0;
            bus.palu_cpr_rd_wdata = (c == v.lat) ? v.data : 32'd0;
            cyc();
            chk("ivalid_exec", 32'(s_ivalid), 32'd1);
            chk("busy_exec", 32'(s_busy), 32'd1);
            if (c == 1) begin
                chk("op_rs1", bus.palu_rs1, v.rs1);
                chk("op_rs2", bus.palu_rs2, v.rs2);
                chk("op_rs3", bus.palu_rs3, v.rs3);
                chk("op_gpr", bus.palu_gpr_rs1, v.gpr);
                chk("op_imm", bus.palu_imm, v.imm);
                chk("op_pw", 32'(bus.palu_pw), 32'(v.pw));
                chk("op_class", 32'(bus.palu_class), 32'(v.cls));
                chk("op_sub", 32'(bus.palu_subclass), 32'(v.sub));
            end
        end
        bus.palu_idone        = 1'b0;
        bus.palu_cpr_rd_ben   = 4'd0;
        bus.palu_cpr_rd_wdata = 32'd0;
        cyc();
        chk("ivalid_wb", 32'(s_ivalid), 32'd0);
        chk("busy_wb", 32'(s_busy), 32'd1);
        chk("wrote_wb", 32'(s_ben != 4'd0), 32'(v.ben != 4'd0));
        cyc();
        chk("ready_end", 32'(s_ready), 32'd1);
        chk("busy_end", 32'(s_busy), 32'd0);
    endtask

    task automatic contend(input bit palu_first);
        vec_t v;
        wr_t  ep;
        wr_t  em;
        v.rs1 = 32'h1111_2222; v.rs2 = 32'h3333_4444; v.rs3 = 32'd0;
        v.gpr = 32'd0; v.imm = 32'd0; v.pw = 3'd1; v.cls = 3'd1;
        v.sub = 4'd0; v.rd = 4'd9; v.lat = 1; v.ben = 4'hF;
        v.data = 32'h0BAD_F00D;
        ep = '{4'd9, 4'hF, 32'h0BAD_F00D};
        em = '{4'd3, 4'hF, 32'hDEAD_BEEF};
        if (palu_first) begin
            sb.push_back(ep);
            sb.push_back(em);
        end else begin
            sb.push_back(em);
            sb.push_back(ep);
        end
        drive_id(v);
        cyc();
        bus.id_valid          = 1'b0;
        bus.palu_idone        = 1'b1;
        bus.palu_cpr_rd_ben   = 4'hF;
        bus.palu_cpr_rd_wdata = 32'h0BAD_F00D;
        cyc();
        bus.palu_idone        = 1'b0;
        bus.palu_cpr_rd_ben   = 4'd0;
        bus.palu_cpr_rd_wdata = 32'd0;
        bus.mem_wen           = 1'b1;
        bus.mem_rd            = 4'd3;
        bus.mem_wdata         = 32'hDEAD_BEEF;
        cyc();
        chk("ack_c2", 32'(s_ack), 32'(!palu_first));
        chk("wr_c2", 32'(s_ben), 32'hF);
        cyc();
        chk("ack_c3", 32'(s_ack), 32'(palu_first));
        chk("wr_c3", 32'(s_ben), 32'hF);
        cyc();
        chk("ready_c4", 32'(s_ready), 32'd1);
        chk("ack_c4", 32'(s_ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n_iv;
        int   n_err;

        tbl[0] = '{32'h0001_0002, 32'h0003_0004, 32'd0, 32'd0, 32'd0,
                   3'd1, 3'd1, 4'd0, 4'd5, 1, 4'hF, 32'h0004_0006};
        tbl[1] = '{32'h0102_0304, 32'h0506_0708, 32'd0, 32'h0000_0010,
                   32'd0, 3'd2, 3'd3, 4'd2, 4'd7, 4, 4'hF, 32'h1234_5678};
        tbl[2] = '{32'hAAAA_0000, 32'h5555_FFFF, 32'h0F0F_0F0F, 32'd0,
                   32'd0, 3'd0, 3'd4, 4'd9, 4'd2, 1, 4'h0, 32'hCAFE_0000};
        tbl[3] = '{32'h8000_0001, 32'h7FFF_FFFE, 32'd0, 32'd0,
                   32'h0000_001F, 3'd4, 3'd2, 4'd5, 4'd15, 2, 4'h3,
                   32'hA5A5_A5A5};
        tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 3'd7, 4'd15, 4'd0,
                   1, 4'h1, 32'hFFFF_FFFF};

        bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_rs3 = '0; bus.id_gpr_rs1 = '0; bus.id_imm = '0;
        bus.id_pw = '0; bus.id_class = '0; bus.id_subclass = '0;
        bus.id_rd = '0; bus.palu_idone = 1'b0;
        bus.palu_cpr_rd_ben = '0; bus.palu_cpr_rd_wdata = '0;
        bus.mem_wen = 1'b0; bus.mem_rd = '0; bus.mem_wdata = '0;

        #2 g_reset = 1'b1;
        repeat (2) @(posedge g_clk);
        #1;
        chk("rst_ready", 32'(bus.id_ready), 32'd1);
        chk("rst_busy", 32'(bus.ctrl_busy), 32'd0);
        chk("rst_ivalid", 32'(bus.palu_ivalid), 32'd0);
        chk("rst_err", 32'(bus.ctrl_err), 32'd0);
        chk("rst_ack", 32'(bus.mem_ack), 32'd0);
        chk("rst_ben", 32'(bus.cpr_rd_ben), 32'd0);
        chk("rst_rs1", bus.palu_rs1, 32'd0);
        g_reset = 1'b0;
        cyc();

        for (int i = 0; i < 5; i++) run_op(tbl[i]);

        // pointer now favours memory after the last PALU write
        contend(1'b0);

        bus.mem_wen   = 1'b1;
        bus.mem_rd    = 4'd6;
        bus.mem_wdata = 32'h600D_CAFE;
        sb.push_back('{4'd6, 4'hF, 32'h600D_CAFE});
        cyc();
        chk("mem_solo_ack", 32'(s_ack), 32'd1);
        cyc();
        chk("mem_solo_done", 32'(s_ack), 32'd0);

        contend(1'b1);
        contend(1'b1);

        v = tbl[1];
        v.lat = 1000;
        v.ben = 4'd0;
        drive_id(v);
        cyc();
        bus.id_valid = 1'b0;
        cyc();
        g_reset = 1'b1;
        #1;
        chk("mid_rst_ivalid", 32'(bus.palu_ivalid), 32'd0);
        chk("mid_rst_ready", 32'(bus.id_ready), 32'd1);
        chk("mid_rst_busy", 32'(bus.ctrl_busy), 32'd0);
        @(posedge g_clk);
        #1;
        g_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_ready", 32'(s_ready), 32'd1);
        end

        drive_id(v);
        cyc();
        bus.id_valid = 1'b0;
        n_iv  = 0;
        n_err = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (s_ivalid) n_iv++;
            if (s_err) n_err++;
        end
`ifdef SCARV_COP_PALU_CTRL_TIMEOUT_EN
        chk("tmo_ivalid_cycles", 32'(n_iv), 32'd8);
        chk("tmo_err_pulses", 32'(n_err), 32'd1);
        chk("tmo_ready", 32'(s_ready), 32'd1);
`else
        chk("noto_ivalid_cycles", 32'(n_iv), 32'd20);
        chk("noto_err", 32'(n_err), 32'd0);
        chk("noto_busy", 32'(s_busy), 32'd1);
        g_reset = 1'b1;
        cyc();
        g_reset = 1'b0;
        cyc();
        chk("noto_recover", 32'(s_ready), 32'd1);
`endif
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
